// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - 32-bit mode-0 SPI frame master with CS setup/hold timing
// Optional reply capture is enabled by defining SPI_RX_CAPTURE_EN.
module spi_frame_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        SysClock,
    input  logic        SysReset_n,
    input  logic        SPI_START,
    input  logic [31:0] SPI_TX,
    output logic        SPI_DONE,
    output logic        SPI_BUSY,
    output logic [31:0] SPI_RX,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SPI_CS_n
);

    localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                             ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                             ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, FINISH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [31:0]   tx_sh_q, tx_sh_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          sample_en;
    logic          load_rx;

    always_ff @(posedge SysClock or negedge SysReset_n) begin
        if (!SysReset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_sh_q <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_sh_q <= tx_sh_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // One shared counter times setup, each SCK half-period, and hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        sample_en = 1'b0;
        load_rx   = 1'b0;
        case (state_q)
            IDLE: begin
                if (SPI_START) begin
                    state_d = SETUP;
                    tx_sh_d = SPI_TX;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                cs_n_d = 1'b0;
                mosi_d = tx_sh_q[31];
                if (cnt_q == CW'(CS_SETUP)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d     = 1'b1;
                        sample_en = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 6'd31) begin
                            mosi_d  = 1'b0;
                            state_d = HOLD;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            mosi_d  = tx_sh_q[30];
                            tx_sh_d = {tx_sh_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    state_d = FINISH;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    load_rx = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_RX_CAPTURE_EN
    logic [31:0] cap_q;
    logic [31:0] rx_q;

    always_ff @(posedge SysClock or negedge SysReset_n) begin
        if (!SysReset_n) begin
            cap_q <= '0;
            rx_q  <= '0;
        end else begin
            if (sample_en) cap_q <= {cap_q[30:0], SPI_MISO};
            if (load_rx)   rx_q  <= cap_q;
        end
    end

    assign SPI_RX = rx_q;
`else
    logic unused_capture;
    assign unused_capture = ^{SPI_MISO, sample_en, load_rx};
    assign SPI_RX = '0;
`endif

    assign SPI_DONE = done_q;
    assign SPI_BUSY = busy_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - random-stimulus bench with a time-since-START model for spi_frame_master
module tb_spi_frame_master;

    localparam int S = 2;
    localparam int H = 2;
`ifdef SPI_RX_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    function automatic int dv(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int tend(input int d);
        return 1 + S + 64 * dv(d) + H;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] tx = '0;
    logic        miso_b = 1'b0;
    logic [1:0]  done_w, busy_w, sck_w, mosi_w, csn_w;
    logic [31:0] rx_w [2];
    wire  [1:0]  miso_w = {miso_b, mosi_w[0]};

    int total = 0;
    int bad = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    spi_frame_master u_a (
        .SysClock(clk), .SysReset_n(rst_n), .SPI_START(start), .SPI_TX(tx),
        .SPI_DONE(done_w[0]), .SPI_BUSY(busy_w[0]), .SPI_RX(rx_w[0]),
        .SPI_SCK(sck_w[0]), .SPI_MOSI(mosi_w[0]), .SPI_MISO(mosi_w[0]), .SPI_CS_n(csn_w[0])
    );

    spi_frame_master #(.CLK_DIV(1)) u_b (
        .SysClock(clk), .SysReset_n(rst_n), .SPI_START(start), .SPI_TX(tx),
        .SPI_DONE(done_w[1]), .SPI_BUSY(busy_w[1]), .SPI_RX(rx_w[1]),
        .SPI_SCK(sck_w[1]), .SPI_MOSI(mosi_w[1]), .SPI_MISO(miso_b), .SPI_CS_n(csn_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Model: each frame is described only by the number of edges since START acceptance.
    bit          act_m [2];
    int          t_m [2];
    logic [31:0] word_m [2];
    logic [31:0] rxsh_m [2];
    logic [31:0] rxexp_m [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                act_m[d] = 1'b0;
                t_m[d] = 0;
                rxsh_m[d] = '0;
                rxexp_m[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!act_m[d]) begin
                    if (start) begin
                        act_m[d] = 1'b1;
                        t_m[d] = 0;
                        word_m[d] = tx;
                    end
                end else begin
                    int fs;
                    fs = 1 + S;
                    t_m[d]++;
                    if (t_m[d] >= fs + dv(d) && t_m[d] < fs + 64 * dv(d) &&
                        ((t_m[d] - fs - dv(d)) % (2 * dv(d))) == 0)
                        rxsh_m[d] = {rxsh_m[d][30:0], miso_w[d]};
                    if (t_m[d] == tend(d) && CAP) rxexp_m[d] = rxsh_m[d];
                    if (t_m[d] == tend(d) + 1) act_m[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                logic e_busy, e_csn, e_done, e_sck, e_mosi;
                int tt, fs, dd, b;
                tt = t_m[d];
                fs = 1 + S;
                dd = dv(d);
                e_busy = act_m[d];
                e_csn = !(act_m[d] && tt >= 1 && tt <= tend(d) - 1);
                e_done = act_m[d] && tt == tend(d);
                e_sck = act_m[d] && tt >= fs && tt < fs + 64 * dd && (((tt - fs) / dd) % 2) == 1;
                b = (tt < fs) ? 0 : (tt - fs) / (2 * dd);
                e_mosi = (act_m[d] && tt >= 1 && tt < fs + 64 * dd) ? word_m[d][31 - b] : 1'b0;
                chk($sformatf("d%0d_done", d), {31'b0, done_w[d]}, {31'b0, e_done});
                chk($sformatf("d%0d_busy", d), {31'b0, busy_w[d]}, {31'b0, e_busy});
                chk($sformatf("d%0d_csn", d), {31'b0, csn_w[d]}, {31'b0, e_csn});
                chk($sformatf("d%0d_sck", d), {31'b0, sck_w[d]}, {31'b0, e_sck});
                chk($sformatf("d%0d_mosi", d), {31'b0, mosi_w[d]}, {31'b0, e_mosi});
                chk($sformatf("d%0d_rx", d), rx_w[d], rxexp_m[d]);
            end
        end
    end

    // Edge counter, SCK-rise MOSI capture, DONE bookkeeping and the B-side slave.
    int          cyc = 0;
    int          rises [2];
    int          ndone [2];
    int          done_edge [2];
    int          cslow = 0;
    int          nb = 0;
    logic [31:0] mcap [2];
    logic [31:0] slave_word = '0;
    logic [1:0]  psck = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sck_w[d] && !psck[d]) begin
                rises[d]++;
                mcap[d] = {mcap[d][30:0], mosi_w[d]};
                if (d == 1) nb++;
            end
            psck[d] = sck_w[d];
            if (done_w[d]) begin
                ndone[d]++;
                done_edge[d] = cyc;
            end
        end
        if (!csn_w[0]) cslow++;
        if (csn_w[1]) nb = 0;
        miso_b = (nb < 32) ? slave_word[31 - nb] : 1'b0;
    end

    int e0 = 0;

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            rises[d] = 0;
            ndone[d] = 0;
        end
        cslow = 0;
    endtask

    task automatic pulse(input logic [31:0] w);
        @(negedge clk);
        start = 1'b1;
        tx = w;
        @(negedge clk);
        start = 1'b0;
        tx = $urandom;
        e0 = cyc;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (!done_w[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done_w[d]) chk($sformatf("timeout_d%0d", d), {31'b0, done_w[d]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, r;
        logic        rc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        chk("rst_done", {31'b0, done_w[0]}, 32'd0);
        chk("rst_busy", {31'b0, busy_w[0]}, 32'd0);
        chk("rst_csn", {31'b0, csn_w[0]}, 32'd1);
        chk("rst_sck", {31'b0, sck_w[0]}, 32'd0);
        chk("rst_mosi", {31'b0, mosi_w[0]}, 32'd0);
        chk("rst_rx", rx_w[0], 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known-word frame on both DUTs.
        slave_word = 32'hA5C3_0F96;
        clr();
        pulse(32'h1234_5678);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("a_done_edge", done_edge[0] - e0, 32'd261);
        chk("a_rises", rises[0], 32'd32);
        chk("a_mosi_word", mcap[0], 32'h1234_5678);
        chk("a_cs_low", cslow, 32'd260);
        chk("a_ndone", ndone[0], 32'd1);
        chk("a_rx", rx_w[0], CAP ? 32'h1234_5678 : 32'd0);
        chk("b_done_edge", done_edge[1] - e0, 32'd69);
        chk("b_rises", rises[1], 32'd32);
        chk("b_mosi_word", mcap[1], 32'h1234_5678);
        chk("b_rx", rx_w[1], CAP ? 32'hA5C3_0F96 : 32'd0);

        // START re-pulsed mid-frame with a different word.
        w = $urandom;
        slave_word = $urandom;
        clr();
        pulse(w);
        while (cyc < e0 + 50) @(negedge clk);
        start = 1'b1;
        tx = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("ign_mosi_word", mcap[0], w);
        chk("ign_ndone_a", ndone[0], 32'd1);
        chk("ign_ndone_b", ndone[1], 32'd1);

        // Reset mid-frame, then a clean frame.
        clr();
        pulse($urandom);
        while (cyc < e0 + 100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csn", {31'b0, csn_w[0]}, 32'd1);
        chk("mid_rst_sck", {31'b0, sck_w[0]}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_w[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("mid_rst_ndone", ndone[0], 32'd0);
        w = $urandom;
        clr();
        pulse(w);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("post_rst_done_edge", done_edge[0] - e0, 32'd261);
        chk("post_rst_mosi_word", mcap[0], w);

        // Sequencer-style stream: chip 3, engines 0-15, READ COMPLETE set then clear.
        clr();
        for (int i = 0; i < 32; i++) begin
            r = $urandom;
            rc = (i < 16);
            w = {4'd3, 4'(i % 16), r[23:0]};
            w[18] = rc;
            slave_word = $urandom;
            pulse(w);
            wait_done(0);
            @(negedge clk);
            chk($sformatf("seq%0d_bit18", i), {31'b0, mcap[0][18]}, {31'b0, rc});
        end
        repeat (2) @(negedge clk);
        chk("seq_ndone_a", ndone[0], 32'd32);
        chk("seq_ndone_b", ndone[1], 32'd32);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
